// File: rtl/hex_scroll_pkg.sv
// rtl/hex_scroll_pkg.sv - shared constants, state type and window helper for hex_scroll_ctrl
package hex_scroll_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_MSG_LO = 2'd2;
    localparam logic [1:0] ADDR_MSG_HI = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_WRAP    = 1;
    localparam int CTRL_PTR_LSB = 8;
    localparam int CTRL_BUSY    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_COUNT = 2'd3
    } state_t;

    localparam logic [23:0] DIV_RESET = 24'h0F4240;
    localparam logic [31:0] SEG_BLANK = 32'h40404040;

    // Four consecutive message bytes starting at ptr, wrapping modulo 8.
    function automatic logic [31:0] window(input logic [63:0] msg, input logic [2:0] ptr);
        logic [31:0] w;
        logic [2:0]  idx;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 3'(k);
            w[8*k +: 8] = msg[8*idx +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_scroll_tick.sv
// rtl/hex_scroll_tick.sv - scroll period down-counter with zero flag
module hex_scroll_tick
    import hex_scroll_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        dec,
    input  logic [23:0] period,
    output logic        zero
);

    logic [23:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= period;
        end else if (dec && (count != 24'd0)) begin
            count <= count - 24'd1;
        end
    end

    assign zero = (count == 24'd0);

endmodule

// File: rtl/hex_scroll_ctrl.sv
// rtl/hex_scroll_ctrl.sv - scrolls an 8-byte message through a 4-digit segment PIO
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  seg_address,
    output logic        seg_chipselect,
    output logic        seg_write_n,
    output logic [31:0] seg_writedata,
    output logic        busy
);

    state_t      state, state_nxt;
    logic        en, wrap;
    logic [23:0] div;
    logic [31:0] msg_lo, msg_hi;
    logic [2:0]  ptr;
    logic        tick_zero;

    logic cfg_wr, ctrl_wr, start, stop_sw, hw_stop, advance;

    assign cfg_wr  = cfg_chipselect && !cfg_write_n;
    assign ctrl_wr = cfg_wr && (cfg_address == ADDR_CTRL);
    assign start   = (state == ST_IDLE) && ctrl_wr && cfg_writedata[CTRL_EN];
    assign stop_sw = (state != ST_IDLE) && ctrl_wr && !cfg_writedata[CTRL_EN];
    // A simultaneous software CTRL write overrides the one-shot auto stop.
    assign hw_stop = (state == ST_WRITE) && !wrap && (ptr == 3'd4) && !ctrl_wr;
    assign advance = (state == ST_COUNT) && tick_zero && (state_nxt == ST_LOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = hw_stop ? ST_IDLE : ST_COUNT;
            ST_COUNT: if (tick_zero) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
        if (stop_sw) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            en            <= 1'b0;
            wrap          <= 1'b0;
            div           <= DIV_RESET;
            msg_lo        <= SEG_BLANK;
            msg_hi        <= SEG_BLANK;
            ptr           <= 3'd0;
            seg_writedata <= SEG_BLANK;
        end else begin
            state <= state_nxt;
            if (ctrl_wr) begin
                en   <= cfg_writedata[CTRL_EN];
                wrap <= cfg_writedata[CTRL_WRAP];
            end else if (hw_stop) begin
                en   <= 1'b0;
            end
            if (cfg_wr && (cfg_address == ADDR_DIV))    div    <= cfg_writedata[23:0];
            if (cfg_wr && (cfg_address == ADDR_MSG_LO)) msg_lo <= cfg_writedata;
            if (cfg_wr && (cfg_address == ADDR_MSG_HI)) msg_hi <= cfg_writedata;
            if (start) begin
                ptr <= 3'd0;
            end else if (advance) begin
                ptr <= ptr + 3'd1;
            end
            if (state == ST_LOAD) seg_writedata <= window({msg_hi, msg_lo}, ptr);
        end
    end

    hex_scroll_tick u_tick (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_LOAD),
        .dec    (state == ST_COUNT),
        .period (div),
        .zero   (tick_zero)
    );

    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            ADDR_CTRL: begin
                cfg_readdata[CTRL_EN]                    = en;
                cfg_readdata[CTRL_WRAP]                  = wrap;
                cfg_readdata[CTRL_PTR_LSB +: 3]          = ptr;
                cfg_readdata[CTRL_BUSY]                  = busy;
            end
            ADDR_DIV:    cfg_readdata[23:0] = div;
            ADDR_MSG_LO: cfg_readdata       = msg_lo;
            ADDR_MSG_HI: cfg_readdata       = msg_hi;
            default:     cfg_readdata       = '0;
        endcase
    end

    assign seg_address    = 2'b00;
    assign seg_chipselect = (state == ST_WRITE);
    assign seg_write_n    = (state != ST_WRITE);
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb/tb_hex_scroll_ctrl.sv - scoreboard bench for hex_scroll_ctrl
module tb_hex_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_address = 2'd0;
    logic        cfg_chipselect = 1'b0;
    logic        cfg_write_n = 1'b1;
    logic [31:0] cfg_writedata = 32'd0;
    logic [31:0] cfg_readdata;
    logic [1:0]  seg_address;
    logic        seg_chipselect;
    logic        seg_write_n;
    logic [31:0] seg_writedata;
    logic        busy;

    hex_scroll_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_address    (cfg_address),
        .cfg_chipselect (cfg_chipselect),
        .cfg_write_n    (cfg_write_n),
        .cfg_writedata  (cfg_writedata),
        .cfg_readdata   (cfg_readdata),
        .seg_address    (seg_address),
        .seg_chipselect (seg_chipselect),
        .seg_write_n    (seg_write_n),
        .seg_writedata  (seg_writedata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    int          gap_q[$];
    int          exp_total = 0;
    int          pulses = 0;
    int          last_cyc = 0;
    int          base;
    logic [63:0] msg = {32'h07060504, 32'h03020100};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] win(input logic [63:0] m, input int p);
        logic [31:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 8;
            r[8*k +: 8] = m[8*idx +: 8];
        end
        return r;
    endfunction

    task automatic push(input int p, input int gap);
        exp_q.push_back(win(msg, p));
        gap_q.push_back(gap);
        exp_total++;
    endtask

    // Pulse monitor: pops the scoreboard on every master write strobe.
    always @(negedge clk) begin
        if (seg_chipselect && !seg_write_n) begin
            int g;
            pulses++;
            if (exp_q.size() == 0) begin
                check("pulse_count", pulses, exp_total);
            end else begin
                check("pulse_data", seg_writedata, exp_q.pop_front());
                g = gap_q.pop_front();
                if (g != 0) check("pulse_gap", cyc - last_cyc, g);
            end
            last_cyc = cyc;
        end
    end

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_address    = a;
        cfg_writedata  = d;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        @(posedge clk);
        #1;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_address = a;
        #1;
        check(tag, cfg_readdata, exp);
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulses < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pulses < target) check("wait_pulses_timeout", pulses, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        // Reset values before any configuration
        check("rst_seg_data", seg_writedata, 32'h40404040);
        check("rst_seg_cs", {31'd0, seg_chipselect}, 32'd0);
        check("rst_seg_wn", {31'd0, seg_write_n}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        rd_check("rst_ctrl", 2'd0, 32'd0);
        rd_check("rst_div", 2'd1, 32'h000F4240);
        rd_check("rst_msg_lo", 2'd2, 32'h40404040);
        repeat (100) @(negedge clk);
        #1;
        check("idle_pulses", pulses, 0);
        check("seg_address", {30'd0, seg_address}, 32'd0);

        // One-shot scroll, DIV=2
        cfg_wr(2'd2, 32'h03020100);
        cfg_wr(2'd3, 32'h07060504);
        cfg_wr(2'd1, 32'd2);
        rd_check("msg_hi_rd", 2'd3, 32'h07060504);
        push(0, 0);
        for (int p = 1; p < 5; p++) push(p, 5);
        cfg_wr(2'd0, 32'h1);
        wait_pulses(5, 200);
        wait_idle(50);
        rd_check("oneshot_ctrl", 2'd0, 32'h00000400);
        repeat (20) @(negedge clk);
        #1;
        check("oneshot_pulses", pulses, 5);
        check("oneshot_drained", exp_q.size(), 0);

        // Wrapping scroll, then software stop mid-COUNT
        base = pulses;
        push(0, 0);
        for (int i = 1; i < 11; i++) push(i % 8, 5);
        cfg_wr(2'd0, 32'h3);
        wait_pulses(base + 9, 300);
        @(negedge clk);
        #1;
        rd_check("wrap_ctrl_p0", 2'd0, 32'h00010003);
        wait_pulses(base + 11, 100);
        @(negedge clk);
        #1;
        cfg_wr(2'd0, 32'h0);
        repeat (30) @(negedge clk);
        #1;
        rd_check("stop_ctrl_hold", 2'd0, 32'h00000200);
        check("stop_pulses", pulses, base + 11);

        // DIV change takes effect only at the following LOAD
        base = pulses;
        push(0, 0);
        push(1, 5);
        push(2, 13);
        push(3, 13);
        cfg_wr(2'd0, 32'h3);
        wait_pulses(base + 1, 50);
        @(negedge clk);
        #1;
        cfg_wr(2'd1, 32'd10);
        wait_pulses(base + 4, 200);
        cfg_wr(2'd0, 32'h0);
        repeat (40) @(negedge clk);
        #1;
        check("div_pulses", pulses, base + 4);
        rd_check("div_rd", 2'd1, 32'h0000000A);

        // Reset asserted during WRITE
        cfg_wr(2'd1, 32'd2);
        base = pulses;
        push(0, 0);
        cfg_wr(2'd0, 32'h1);
        wait_pulses(base + 1, 50);
        reset = 1'b1;
        #1;
        check("mid_rst_cs", {31'd0, seg_chipselect}, 32'd0);
        check("mid_rst_wn", {31'd0, seg_write_n}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", seg_writedata, 32'h40404040);
        rd_check("mid_rst_ctrl", 2'd0, 32'd0);
        rd_check("mid_rst_div", 2'd1, 32'h000F4240);
        rd_check("mid_rst_msg_hi", 2'd3, 32'h40404040);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("post_rst_pulses", pulses, base + 1);
        check("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
